prbs_gen_chk: RTL and testbench
===============================

// Module: prbs_gen_chk
// PURPOSE
//  Multi-polynomial PRBS generator plus self-synchronising checker for link/IO BIST.
//  Generator emits W bits per enabled clock; checker locks to an incoming PRBS word stream.
//  The checker counts bit errors. The block sits between the top-level pins and test logic.
// PARAMETERS
//  W      8   bits per word (1..16); generator and checker each advance W LFSR steps per word
//  CNT_W  16  error counter width; counter saturates at all-ones
//  LOCK_N 4   consecutive error-free words needed in HUNT to reach LOCKED (1..15)
//  LOSS_N 4   consecutive errored words in LOCKED that force a return to HUNT (1..15)
// PORTS
//  clk         in  1     clock
//  rst_n       in  1     async active-low reset
//  mode        in  2     polynomial: 0=PRBS7 x7+x6+1, 1=PRBS15 x15+x14+1, 2=PRBS23 x23+x18+1, 3=PRBS31 x31+x28+1
//  gen_en      in  1     advance generator one word
//  seed_load   in  1     load generator state from seed (priority over gen_en)
//  seed        in  31    seed; low N bits used (N=7/15/23/31)
//  gen_data    out W     generated word; [W-1] is the oldest bit
//  gen_valid   out 1     gen_data updated this cycle
//  chk_en      in  1     chk_data valid this cycle
//  chk_data    in  W     received word; [W-1] is the oldest bit
//  chk_locked  out 1     checker in LOCKED
//  err_cnt     out CNT_W saturating bit-error count, accumulated only while LOCKED
//  err_clr     in  1     synchronous clear of err_cnt
//  err_inject  in  1     (ERR_INJECT_EN only) invert gen_data[0] of the next word
// BEHAVIOUR
//  Reset: gen state = 31'd1, gen_data = 0, gen_valid = 0, checker state = 0, HUNT, chk_locked = 0, err_cnt = 0.
//  LFSR (Fibonacci): state shifts left, new bit in [0] = s[N-1]^s[tap], output bit = s[N-1].
//    tap = 5/13/17/27. Only bits [N-1:0] are significant; upper bits are held 0.
//  Generator: on seed_load, state <= seed[N-1:0], or 1 if that slice is zero; gen_valid = 0.
//    Otherwise on gen_en, gen_data <= next W output bits and state advances W steps; gen_valid = 1 the next cycle.
//    Latency: gen_en at cycle t gives gen_data/gen_valid at t+1. Without gen_en, gen_data holds and gen_valid = 0.
//  Checker FSM (evaluated per chk_en word; idle cycles change nothing):
//    HUNT: for each bit, predicted = c[N-1]^c[tap]; c shifts in the RECEIVED bit (self-sync).
//      Any mismatch in the word clears good_cnt; a clean word increments it.
//      When good_cnt reaches LOCK_N -> LOCKED, and chk_locked = 1 the next cycle.
//      An all-zero checker state never counts as clean; this prevents false lock on an idle line.
//    LOCKED: c free-runs, shifting in the PREDICTED bit.
//      err_cnt += popcount(chk_data ^ predicted word), saturating.
//      A word with >=1 error increments bad_cnt; a clean word clears it.
//      When bad_cnt reaches LOSS_N -> HUNT, chk_locked = 0, and c reseeds from received bits.
//  Simultaneous err_clr and a counted error: the clear wins, so err_cnt = 0 that cycle.
//  A change of mode (sampled each cycle) forces the checker to HUNT and clears good_cnt and bad_cnt.
//    The generator keeps its state and switches taps; if the new low-N slice is zero, the state is forced to 1.
//  Generator and checker are independent; gen_data may be looped back to chk_data externally.
//  Async reset mid-word aborts everything to the reset values above; there is no partial-word state.
// CONFIGURATION
//  ERR_INJECT_EN defined: err_inject port exists.
//    A pulse flips bit 0 of the next generated word only; LFSR state is unaffected.
//    A pulse with no gen_en stays pending until the next gen_en.
//  ERR_INJECT_EN undefined: port absent; gen_data is always the pure sequence.
// TESTING
//  mode=0, W=1, seed_load seed=1, gen_en held -> sequence period 127, state never zero, 64 ones per period.
//  mode=3, W=8, loopback gen->chk -> chk_locked=1 by word LOCK_N+4 (31 bits fill + 4 clean words); err_cnt stays 0 for 10^4 words.
//  Locked loopback, ERR_INJECT_EN, one err_inject pulse -> err_cnt = 1 exactly; chk_locked stays 1.
//  Locked, chk_data forced to 8'h00 for LOSS_N words -> chk_locked=0 the cycle after word LOSS_N; no relock while data stays 0.
//  CNT_W=4, locked, inject 20 errors -> err_cnt = 4'hF (saturated); err_clr -> 0; err_clr with a simultaneous error -> 0.
//  Locked on mode=1, switch to mode=2 mid-stream -> chk_locked=0 next cycle; relock on PRBS23 after 23 bits + LOCK_N clean words.

Source files
------------

// File: rtl/prbs_gen_chk.sv
// Multi-polynomial PRBS generator plus self-synchronising PRBS checker for link/IO BIST.
// Build option: define ERR_INJECT_EN to add the err_inject port (flips bit 0 of the next generated word).
module prbs_gen_chk #(
  parameter int W      = 8,
  parameter int CNT_W  = 16,
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             gen_en,
  input  logic             seed_load,
  input  logic [30:0]      seed,
  output logic [W-1:0]     gen_data,
  output logic             gen_valid,
  input  logic             chk_en,
  input  logic [W-1:0]     chk_data,
  output logic             chk_locked,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
`ifdef ERR_INJECT_EN
  ,
  input  logic             err_inject
`endif
);

  localparam int         PC_W      = $clog2(W + 1);
  localparam int         SUM_W     = CNT_W + PC_W;
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_N - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_N - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  function automatic logic [30:0] len_mask(input logic [1:0] m);
    case (m)
      2'd0:    len_mask = 31'h0000_007F;
      2'd1:    len_mask = 31'h0000_7FFF;
      2'd2:    len_mask = 31'h007F_FFFF;
      default: len_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic [4:0] msb_idx(input logic [1:0] m);
    case (m)
      2'd0:    msb_idx = 5'd6;
      2'd1:    msb_idx = 5'd14;
      2'd2:    msb_idx = 5'd22;
      default: msb_idx = 5'd30;
    endcase
  endfunction

  function automatic logic [4:0] tap_idx(input logic [1:0] m);
    case (m)
      2'd0:    tap_idx = 5'd5;
      2'd1:    tap_idx = 5'd13;
      2'd2:    tap_idx = 5'd17;
      default: tap_idx = 5'd27;
    endcase
  endfunction

  function automatic logic fb_bit(input logic [30:0] s, input logic [1:0] m);
    fb_bit = s[msb_idx(m)] ^ s[tap_idx(m)];
  endfunction

  function automatic logic [30:0] shift_in(input logic [30:0] s, input logic b, input logic [1:0] m);
    shift_in = {s[29:0], b} & len_mask(m);
  endfunction

  function automatic logic [30:0] advance(input logic [30:0] s, input logic [1:0] m);
    logic [30:0] t;
    t = s;
    for (int i = 0; i < W; i++) t = shift_in(t, fb_bit(t, m), m);
    advance = t;
  endfunction

  // Generator output bits are the LFSR MSB; the first (oldest) lands in [W-1].
  function automatic logic [W-1:0] out_word(input logic [30:0] s, input logic [1:0] m);
    logic [30:0] t;
    t = s;
    out_word = '0;
    for (int i = 0; i < W; i++) begin
      out_word[W-1-i] = t[msb_idx(m)];
      t = shift_in(t, fb_bit(t, m), m);
    end
  endfunction

  // The checker register holds received history, so the next expected bit is the feedback term.
  function automatic logic [W-1:0] pred_word(input logic [30:0] s, input logic [1:0] m);
    logic [30:0] t;
    t = s;
    pred_word = '0;
    for (int i = 0; i < W; i++) begin
      pred_word[W-1-i] = fb_bit(t, m);
      t = shift_in(t, fb_bit(t, m), m);
    end
  endfunction

  function automatic logic [30:0] rx_shift(input logic [30:0] s, input logic [W-1:0] d,
                                           input logic [1:0] m);
    logic [30:0] t;
    t = s;
    for (int i = 0; i < W; i++) t = shift_in(t, d[W-1-i], m);
    rx_shift = t;
  endfunction

  function automatic logic rx_mismatch(input logic [30:0] s, input logic [W-1:0] d,
                                       input logic [1:0] m);
    logic [30:0] t;
    t = s;
    rx_mismatch = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (fb_bit(t, m) != d[W-1-i]) rx_mismatch = 1'b1;
      t = shift_in(t, d[W-1-i], m);
    end
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [W-1:0] v);
    popcount = '0;
    for (int i = 0; i < W; i++) popcount = popcount + PC_W'(v[i]);
  endfunction

  // ---------------- generator ----------------
  logic [30:0]  gen_state;
  logic [30:0]  gen_base;
  logic [30:0]  seed_next;
  logic [30:0]  gen_next;
  logic [W-1:0] gen_word;
  logic         inj_now;

  // Masking every cycle covers mode switches: upper bits drop and a zero slice becomes 1.
  always_comb begin
    gen_base = gen_state & len_mask(mode);
    if (gen_base == 31'd0) gen_base = 31'd1;
    seed_next = seed & len_mask(mode);
    if (seed_next == 31'd0) seed_next = 31'd1;
  end

  assign gen_word = out_word(gen_base, mode);
  assign gen_next = advance(gen_base, mode);

`ifdef ERR_INJECT_EN
  logic inj_pend;

  assign inj_now = err_inject | inj_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_pend <= 1'b0;
    end else if (gen_en && !seed_load) begin
      inj_pend <= 1'b0;
    end else if (err_inject) begin
      inj_pend <= 1'b1;
    end
  end
`else
  assign inj_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_state <= 31'd1;
      gen_data  <= '0;
      gen_valid <= 1'b0;
    end else begin
      gen_valid <= 1'b0;
      if (seed_load) begin
        gen_state <= seed_next;
      end else if (gen_en) begin
        gen_state <= gen_next;
        gen_data  <= gen_word ^ W'(inj_now);
        gen_valid <= 1'b1;
      end else begin
        gen_state <= gen_base;
      end
    end
  end

  // ---------------- checker ----------------
  chk_state_t       chk_st;
  logic [30:0]      chk_c;
  logic [30:0]      c_base;
  logic [30:0]      c_rx;
  logic [30:0]      c_pred;
  logic [1:0]       mode_q;
  logic             mode_chg;
  logic             clean;
  logic             word_err;
  logic [W-1:0]     err_vec;
  logic [PC_W-1:0]  err_num;
  logic [SUM_W-1:0] err_sum;
  logic [CNT_W-1:0] err_sat;
  logic [3:0]       good_cnt;
  logic [3:0]       bad_cnt;

  assign mode_chg = (mode != mode_q);
  assign c_base   = chk_c & len_mask(mode);
  assign c_rx     = rx_shift(c_base, chk_data, mode);
  assign c_pred   = advance(c_base, mode);
  // A zero register predicts zeros forever; never let that count toward lock.
  assign clean    = !rx_mismatch(c_base, chk_data, mode) && (c_base != 31'd0);
  assign err_vec  = chk_data ^ pred_word(c_base, mode);
  assign err_num  = popcount(err_vec);
  assign word_err = |err_vec;
  assign err_sum  = SUM_W'(err_cnt) + SUM_W'(err_num);
  assign err_sat  = (err_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_st     <= HUNT;
      chk_locked <= 1'b0;
      chk_c      <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      err_cnt    <= '0;
      mode_q     <= 2'd0;
    end else begin
      mode_q <= mode;

      if (err_clr) begin
        err_cnt <= '0;
      end else if (chk_en && !mode_chg && (chk_st == LOCKED)) begin
        err_cnt <= err_sat;
      end

      if (mode_chg) begin
        chk_st     <= HUNT;
        chk_locked <= 1'b0;
        good_cnt   <= '0;
        bad_cnt    <= '0;
        chk_c      <= chk_en ? c_rx : c_base;
      end else if (chk_en) begin
        case (chk_st)
          HUNT: begin
            chk_c <= c_rx;
            if (!clean) begin
              good_cnt <= '0;
            end else if (good_cnt == LOCK_LAST) begin
              chk_st     <= LOCKED;
              chk_locked <= 1'b1;
              good_cnt   <= '0;
              bad_cnt    <= '0;
            end else begin
              good_cnt <= good_cnt + 4'd1;
            end
          end
          LOCKED: begin
            if (!word_err) begin
              bad_cnt <= '0;
              chk_c   <= c_pred;
            end else if (bad_cnt == LOSS_LAST) begin
              // Lost sync: reseed from the line so the hunt restarts on real data.
              chk_st     <= HUNT;
              chk_locked <= 1'b0;
              bad_cnt    <= '0;
              good_cnt   <= '0;
              chk_c      <= c_rx;
            end else begin
              bad_cnt <= bad_cnt + 4'd1;
              chk_c   <= c_pred;
            end
          end
          default: begin
            chk_st     <= HUNT;
            chk_locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: generator words go through an expected queue checked by a monitor,
// checker lock/loss/error counting is checked with directed streams and hand-derived values.
module tb_prbs_gen_chk;
  localparam int W      = 8;
  localparam int CNT_W  = 4;
  localparam int LOCK_N = 4;
  localparam int LOSS_N = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             gen_en = 1'b0;
  logic             seed_load = 1'b0;
  logic [30:0]      seed = 31'd0;
  logic [W-1:0]     gen_data;
  logic             gen_valid;
  logic             chk_en = 1'b0;
  logic [W-1:0]     chk_data = '0;
  logic             chk_locked;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr = 1'b0;
`ifdef ERR_INJECT_EN
  logic             err_inject = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] mon_exp;
  logic [30:0]  m_gen;
  logic [30:0]  m_chk;

  always #5 clk = ~clk;

  prbs_gen_chk #(.W(W), .CNT_W(CNT_W), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .gen_en     (gen_en),
    .seed_load  (seed_load),
    .seed       (seed),
    .gen_data   (gen_data),
    .gen_valid  (gen_valid),
    .chk_en     (chk_en),
    .chk_data   (chk_data),
    .chk_locked (chk_locked),
    .err_cnt    (err_cnt),
    .err_clr    (err_clr)
`ifdef ERR_INJECT_EN
    ,
    .err_inject (err_inject)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR: emits W output bits (MSB first) and steps the state bit by bit.
  task automatic model_word(inout logic [30:0] st, input logic [1:0] m, output logic [W-1:0] w);
    int n;
    int t;
    logic [30:0] msk;
    logic fb;
    n = (m == 2'd0) ? 7 : (m == 2'd1) ? 15 : (m == 2'd2) ? 23 : 31;
    t = (m == 2'd0) ? 5 : (m == 2'd1) ? 13 : (m == 2'd2) ? 17 : 27;
    msk = 31'((32'd1 << n) - 32'd1);
    w = '0;
    for (int b = 0; b < W; b++) begin
      w  = (w << 1) | W'(st[n-1]);
      fb = st[n-1] ^ st[t];
      st = ((st << 1) | 31'(fb)) & msk;
    end
  endtask

  // One checker word: next reference word XOR flip, optionally with err_clr in the same cycle.
  task automatic send(input logic [W-1:0] flip, input logic clr, output logic [W-1:0] w);
    model_word(m_chk, mode, w);
    chk_data = w ^ flip;
    chk_en   = 1'b1;
    err_clr  = clr;
    tick();
    chk_en  = 1'b0;
    err_clr = 1'b0;
  endtask

  // Scoreboard monitor for the generator.
  always @(negedge clk) begin
    if (rst_n && gen_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL gen_unexpected: got %0h, expected no word", gen_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("gen_data", 32'(gen_data), 32'(mon_exp));
        obs_q.push_back(gen_data);
      end
    end
  end

  initial begin
    #2000000;
    tests++;
    fails++;
    $display("FAIL timeout: got no finish, expected finish within budget");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [W-1:0] w;
    int ones;
    int exp_err;

    repeat (3) @(posedge clk);
    #1;
    check("rst_gen_data", 32'(gen_data), 32'h0);
    check("rst_gen_valid", 32'(gen_valid), 32'h0);
    check("rst_locked", 32'(chk_locked), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // PRBS7 from seed 1: 128 words span 8 full periods plus one word.
    mode = 2'd0;
    seed = 31'd1;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("seed_load_valid", 32'(gen_valid), 32'h0);
    m_gen = 31'd1;
    gen_en = 1'b1;
    for (int k = 0; k < 128; k++) begin
      model_word(m_gen, 2'd0, w);
      exp_q.push_back(w);
      tick();
    end
    gen_en = 1'b0;
    tick();
    check("gen_idle_valid", 32'(gen_valid), 32'h0);
    check("gen_hold", 32'(gen_data), 32'h02);
    check("gen_obs_count", obs_q.size(), 128);
    if (obs_q.size() >= 128) begin
      check("prbs7_word1", 32'(obs_q[0]), 32'h02);
      check("prbs7_word2", 32'(obs_q[1]), 32'h0C);
      check("prbs7_period", 32'(obs_q[127]), 32'h02);
      ones = 0;
      for (int k = 0; k < 127; k++) ones += $countones(obs_q[k]);
      check("prbs7_ones", ones, 512);
    end

    // Zero seed slice forces state 1; seed_load beats gen_en.
    seed = 31'h80;
    seed_load = 1'b1;
    gen_en = 1'b1;
    tick();
    check("seed_priority_valid", 32'(gen_valid), 32'h0);
    seed_load = 1'b0;
    exp_q.push_back(8'h02);
    tick();
    gen_en = 1'b0;
    tick();

`ifdef ERR_INJECT_EN
    err_inject = 1'b1;
    tick();
    err_inject = 1'b0;
    tick();
    tick();
    gen_en = 1'b1;
    exp_q.push_back(8'h0D);
    tick();
    exp_q.push_back(8'h28);
    tick();
    gen_en = 1'b0;
    tick();
`endif

    // Checker on PRBS31: word 1 can never be clean, words 5..8 must be.
    mode = 2'd3;
    tick();
    tick();
    check("mode3_hunt", 32'(chk_locked), 32'h0);
    m_chk = 31'h0123_4567;
    for (int k = 0; k < 4; k++) send('0, 1'b0, w);
    check("prbs31_no_early_lock", 32'(chk_locked), 32'h0);
    for (int k = 0; k < 4; k++) send('0, 1'b0, w);
    check("prbs31_lock", 32'(chk_locked), 32'h1);
    for (int k = 0; k < 10000; k++) send('0, 1'b0, w);
    check("clean_err_cnt", 32'(err_cnt), 32'h0);
    check("clean_locked", 32'(chk_locked), 32'h1);

    send(8'h01, 1'b0, w);
    check("single_err_cnt", 32'(err_cnt), 32'h1);
    check("single_err_locked", 32'(chk_locked), 32'h1);

    // 20 more errors, never LOSS_N errored words in a row: 1 + 20 saturates at 15.
    for (int k = 0; k < 4; k++) begin
      send(8'h1F, 1'b0, w);
      send('0, 1'b0, w);
    end
    check("sat_err_cnt", 32'(err_cnt), 32'hF);
    check("sat_locked", 32'(chk_locked), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_err_cnt", 32'(err_cnt), 32'h0);
    send(8'h01, 1'b1, w);
    check("clr_beats_err", 32'(err_cnt), 32'h0);
    send(8'h10, 1'b0, w);
    check("err_after_clr", 32'(err_cnt), 32'h1);

    // Mode switch drops lock; PRBS15 then PRBS23 mid-stream.
    mode = 2'd1;
    tick();
    check("mode1_unlock", 32'(chk_locked), 32'h0);
    m_chk = 31'h0000_5A5A;
    for (int k = 0; k < 6; k++) send('0, 1'b0, w);
    check("prbs15_lock", 32'(chk_locked), 32'h1);
    check("hunt_no_count", 32'(err_cnt), 32'h1);
    mode = 2'd2;
    m_chk = 31'h003C_1234;
    send('0, 1'b0, w);
    check("mode2_unlock", 32'(chk_locked), 32'h0);
    for (int k = 0; k < 6; k++) send('0, 1'b0, w);
    check("prbs23_relock", 32'(chk_locked), 32'h1);

    // Loss of sync on PRBS7: every 8-bit window holds a one, so all-zero words always err.
    mode = 2'd0;
    m_chk = 31'h0000_0055;
    for (int k = 0; k < 5; k++) send('0, 1'b0, w);
    check("prbs7_lock", 32'(chk_locked), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 0;
    for (int k = 0; k < LOSS_N - 1; k++) begin
      send('0, 1'b0, w);
      chk_data = '0;
      exp_err += 0;
    end
    check("loss_clean_cnt", 32'(err_cnt), 32'h0);
    for (int k = 0; k < LOSS_N - 1; k++) begin
      model_word(m_chk, mode, w);
      exp_err += $countones(w);
      chk_data = '0;
      chk_en = 1'b1;
      tick();
      chk_en = 1'b0;
    end
    check("loss_hold", 32'(chk_locked), 32'h1);
    model_word(m_chk, mode, w);
    exp_err += $countones(w);
    chk_data = '0;
    chk_en = 1'b1;
    tick();
    chk_en = 1'b0;
    check("loss_unlock", 32'(chk_locked), 32'h0);
    check("loss_err_cnt", 32'(err_cnt), (exp_err > 15) ? 32'hF : 32'(exp_err));
    chk_data = '0;
    chk_en = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk_en = 1'b0;
    check("no_relock_zero", 32'(chk_locked), 32'h0);
    check("no_count_hunt", 32'(err_cnt), (exp_err > 15) ? 32'hF : 32'(exp_err));

    tick();
    tick();
    check("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
